dmem_block_responder: RTL and testbench

- Memory-side responder for the pipeline's data-memory interface; the CPU core is the initiator.
- Services word reads and writes in the same cycle they are presented.
- Services 32-byte block reads and writes (cache-line fills and writebacks) after a programmable latency, signalled with single-cycle valid pulses.
- Sits below the data-cache/MEM stage and provides the block-read/block-write valid inputs the core consumes.

---
 rtl/dmem_block_responder.sv | 160 ++++++++++++++++
 tb/tb_dmem_block_responder.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/dmem_block_responder.sv
// Data-memory responder: same-cycle word access plus latency-delayed 32-byte block reads/writes.
// Optional block statistics counters are enabled with `define DMEM_STATS_EN.
module dmem_block_responder #(
  parameter int ADDR_WIDTH    = 10,
  parameter int READ_LATENCY  = 4,
  parameter int WRITE_LATENCY = 4
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic [31:0]  data_address_IN,
  input  logic         MemRead_IN,
  input  logic         MemWrite_IN,
  input  logic [31:0]  data_write_IN,
  input  logic [1:0]   data_write_size_IN,
  output logic [31:0]  data_read_OUT,
  input  logic         dBlkRead_IN,
  input  logic         dBlkWrite_IN,
  input  logic [255:0] block_write_IN,
  output logic [255:0] block_read_OUT,
  output logic         block_read_valid_OUT,
  output logic         block_write_valid_OUT,
  output logic         busy_OUT
`ifdef DMEM_STATS_EN
  ,
  output logic [31:0]  stat_rd_OUT,
  output logic [31:0]  stat_wr_OUT,
  output logic [31:0]  stat_abort_OUT
`endif
);

  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT} state_t;

  logic [31:0] r_mem [0:(1<<ADDR_WIDTH)-1];

  state_t                r_state, w_nxt;
  logic [7:0]            r_cnt, w_cnt_nxt;
  logic [ADDR_WIDTH-4:0] r_line;
  logic [255:0]          r_wblk;
  logic [255:0]          r_blk_rd;
  logic                  r_rd_vld, r_wr_vld;
  logic                  w_rd_done, w_wr_done, w_abort, w_accept;

  logic [ADDR_WIDTH-1:0] w_widx;
  logic [2:0]            w_nbytes;
  logic [3:0]            w_wmask;
  logic [31:0]           w_wdat;
  logic                  w_unused;

  assign w_widx         = data_address_IN[ADDR_WIDTH+1:2];
  assign w_nbytes       = (data_write_size_IN == 2'd0) ? 3'd4 : {1'b0, data_write_size_IN};
  assign data_read_OUT  = r_mem[w_widx];
  assign block_read_OUT = r_blk_rd;
  assign block_read_valid_OUT  = r_rd_vld;
  assign block_write_valid_OUT = r_wr_vld;
  assign busy_OUT       = (r_state != IDLE);
  assign w_unused       = ^{MemRead_IN, data_address_IN[31:ADDR_WIDTH+2]};

  // Big-endian lanes: the n low data bytes land at offsets addr[1:0].., anything past offset 3 is dropped.
  always_comb begin
    w_wmask = '0;
    w_wdat  = '0;
    for (int l = 0; l < 4; l++) begin
      if (l >= int'(data_address_IN[1:0]) && l < int'(data_address_IN[1:0]) + int'(w_nbytes)) begin
        w_wmask[3-l]         = 1'b1;
        w_wdat[8*(3-l) +: 8] = data_write_IN[8*(int'(w_nbytes) - 1 - (l - int'(data_address_IN[1:0]))) +: 8];
      end
    end
  end

  always_comb begin
    w_nxt     = r_state;
    w_cnt_nxt = r_cnt;
    w_rd_done = 1'b0;
    w_wr_done = 1'b0;
    w_abort   = 1'b0;
    w_accept  = 1'b0;
    case (r_state)
      IDLE: begin
        if (dBlkWrite_IN) begin
          w_nxt = WR_WAIT; w_cnt_nxt = 8'(WRITE_LATENCY - 1); w_accept = 1'b1;
        end else if (dBlkRead_IN) begin
          w_nxt = RD_WAIT; w_cnt_nxt = 8'(READ_LATENCY - 1); w_accept = 1'b1;
        end
      end
      RD_WAIT: begin
        if (!dBlkRead_IN) begin
          w_nxt = IDLE; w_abort = 1'b1;
        end else if (r_cnt == 8'd0) begin
          w_nxt = IDLE; w_rd_done = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - 8'd1;
        end
      end
      WR_WAIT: begin
        if (!dBlkWrite_IN) begin
          w_nxt = IDLE; w_abort = 1'b1;
        end else if (r_cnt == 8'd0) begin
          w_nxt = IDLE; w_wr_done = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - 8'd1;
        end
      end
      default: w_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_line   <= '0;
      r_wblk   <= '0;
      r_blk_rd <= '0;
      r_rd_vld <= 1'b0;
      r_wr_vld <= 1'b0;
    end else begin
      r_state  <= w_nxt;
      r_cnt    <= w_cnt_nxt;
      r_rd_vld <= w_rd_done;
      r_wr_vld <= w_wr_done;
      if (w_accept) begin
        r_line <= w_widx[ADDR_WIDTH-1:3];
        r_wblk <= block_write_IN;
      end
      // Sampled before any memory write landing on this same edge.
      if (w_rd_done)
        for (int i = 0; i < 8; i++) r_blk_rd[32*i +: 32] <= r_mem[{r_line, i[2:0]}];
    end
  end

  // Block commit first so a same-edge word write overrides its byte lanes.
  always_ff @(posedge CLK) begin
    if (w_wr_done)
      for (int i = 0; i < 8; i++) r_mem[{r_line, i[2:0]}] <= r_wblk[32*i +: 32];
    if (MemWrite_IN)
      for (int b = 0; b < 4; b++)
        if (w_wmask[b]) r_mem[w_widx][8*b +: 8] <= w_wdat[8*b +: 8];
  end

`ifdef DMEM_STATS_EN
  logic [31:0] r_stat_rd, r_stat_wr, r_stat_abort;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_stat_rd    <= '0;
      r_stat_wr    <= '0;
      r_stat_abort <= '0;
    end else begin
      if (w_rd_done && r_stat_rd != '1)    r_stat_rd    <= r_stat_rd + 32'd1;
      if (w_wr_done && r_stat_wr != '1)    r_stat_wr    <= r_stat_wr + 32'd1;
      if (w_abort && r_stat_abort != '1)   r_stat_abort <= r_stat_abort + 32'd1;
    end
  end

  assign stat_rd_OUT    = r_stat_rd;
  assign stat_wr_OUT    = r_stat_wr;
  assign stat_abort_OUT = r_stat_abort;
`endif

endmodule

// File: tb/tb_dmem_block_responder.sv
// Directed bench for dmem_block_responder: word byte lanes, block latency, priority, abort, alias, reset, collision.
module tb_dmem_block_responder;
  logic         CLK = 1'b0;
  logic         RESET = 1'b0;
  logic [31:0]  data_address_IN = '0;
  logic         MemRead_IN = 1'b0;
  logic         MemWrite_IN = 1'b0;
  logic [31:0]  data_write_IN = '0;
  logic [1:0]   data_write_size_IN = '0;
  logic [31:0]  data_read_OUT;
  logic         dBlkRead_IN = 1'b0;
  logic         dBlkWrite_IN = 1'b0;
  logic [255:0] block_write_IN = '0;
  logic [255:0] block_read_OUT;
  logic         block_read_valid_OUT;
  logic         block_write_valid_OUT;
  logic         busy_OUT;
`ifdef DMEM_STATS_EN
  logic [31:0]  stat_rd_OUT, stat_wr_OUT, stat_abort_OUT;
`endif

  int n_chk = 0;
  int n_pass = 0;

  dmem_block_responder dut (
    .CLK(CLK), .RESET(RESET),
    .data_address_IN(data_address_IN), .MemRead_IN(MemRead_IN), .MemWrite_IN(MemWrite_IN),
    .data_write_IN(data_write_IN), .data_write_size_IN(data_write_size_IN),
    .data_read_OUT(data_read_OUT),
    .dBlkRead_IN(dBlkRead_IN), .dBlkWrite_IN(dBlkWrite_IN), .block_write_IN(block_write_IN),
    .block_read_OUT(block_read_OUT), .block_read_valid_OUT(block_read_valid_OUT),
    .block_write_valid_OUT(block_write_valid_OUT), .busy_OUT(busy_OUT)
`ifdef DMEM_STATS_EN
    , .stat_rd_OUT(stat_rd_OUT), .stat_wr_OUT(stat_wr_OUT), .stat_abort_OUT(stat_abort_OUT)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick;
    @(posedge CLK); #1;
  endtask

  task automatic wr_word(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
    data_address_IN = a; data_write_IN = d; data_write_size_IN = sz; MemWrite_IN = 1'b1;
    tick;
    MemWrite_IN = 1'b0;
  endtask

  task automatic rd_word(input string tag, input logic [31:0] a, input logic [31:0] exp);
    @(negedge CLK);
    data_address_IN = a;
    #1 check(tag, data_read_OUT, exp);
  endtask

  // Returns edges counted until the selected valid is seen, or -1 on timeout.
  task automatic wait_valid(input bit rd, input int maxc, output int lat);
    lat = -1;
    for (int k = 1; k <= maxc; k++) begin
      tick;
      if (rd ? block_read_valid_OUT : block_write_valid_OUT) begin
        lat = k;
        return;
      end
    end
  endtask

  initial begin
    logic [255:0] blk, dead;
    int lat;
    logic seen;

    repeat (2) @(posedge CLK);
    #1;
    check("rst_rvld", block_read_valid_OUT, 1'b0);
    check("rst_wvld", block_write_valid_OUT, 1'b0);
    check("rst_busy", busy_OUT, 1'b0);
    check("rst_rdata", block_read_OUT, '0);
    @(negedge CLK) RESET = 1'b1;
    tick;

    // Word writes: big-endian byte lanes, partial sizes, tail bytes dropped.
    wr_word(32'h100, 32'hAABBCCDD, 2'd0);
    wr_word(32'h102, 32'h00000011, 2'd1);
    rd_word("wd_size1", 32'h100, 32'hAABB11DD);
    wr_word(32'h104, 32'h00000000, 2'd0);
    wr_word(32'h103, 32'h00001234, 2'd2);
    rd_word("wd_spill", 32'h100, 32'hAABB1112);
    rd_word("wd_nospill", 32'h104, 32'h00000000);
    wr_word(32'h101, 32'h00C0FFEE, 2'd3);
    rd_word("wd_size3", 32'h100, 32'hAAC0FFEE);

    // Block read of line 0x120 holding 1..8; address moved while waiting.
    for (int i = 0; i < 8; i++) wr_word(32'h120 + 32'(4*i), 32'(i + 1), 2'd0);
    data_address_IN = 32'h120; dBlkRead_IN = 1'b1;
    tick;
    data_address_IN = 32'h0;
    wait_valid(1'b1, 20, lat);
    check("rd_latency", lat, 4);
    check("rd_word0", block_read_OUT[31:0], 32'd1);
    check("rd_word7", block_read_OUT[255:224], 32'd8);
    check("rd_busy", busy_OUT, 1'b0);
    dBlkRead_IN = 1'b0;
    tick;
    check("rd_pulse", block_read_valid_OUT, 1'b0);
    check("rd_hold", block_read_OUT[255:224], 32'd8);

    // Write beats read when both requested; the held read then returns the new line.
    for (int i = 0; i < 8; i++) blk[32*i +: 32] = 32'hB000_0000 + 32'(i);
    data_address_IN = 32'h40; block_write_IN = blk;
    dBlkWrite_IN = 1'b1; dBlkRead_IN = 1'b1;
    tick;
    check("pri_busy", busy_OUT, 1'b1);
    wait_valid(1'b0, 20, lat);
    check("pri_wlat", lat, 4);
    check("pri_norvld", block_read_valid_OUT, 1'b0);
    dBlkWrite_IN = 1'b0;
    // Read is accepted on the next edge, then needs 4 more.
    wait_valid(1'b1, 20, lat);
    check("pri_rlat", lat, 5);
    check("pri_rdata", block_read_OUT, blk);
    dBlkRead_IN = 1'b0;
    tick;

    // Abort a block write after 2 cycles in WR_WAIT.
    dead = {8{32'hDEADBEEF}};
    block_write_IN = dead; data_address_IN = 32'h40; dBlkWrite_IN = 1'b1;
    tick;
    seen = 1'b0;
    repeat (2) begin tick; seen |= block_write_valid_OUT; end
    dBlkWrite_IN = 1'b0;
    tick;
    check("ab_busy", busy_OUT, 1'b0);
    seen |= block_write_valid_OUT;
    repeat (4) begin tick; seen |= block_write_valid_OUT; end
    check("ab_novalid", seen, 1'b0);
    rd_word("ab_mem0", 32'h40, 32'hB0000000);
    rd_word("ab_mem7", 32'h5C, 32'hB0000007);
    rd_word("alias", 32'h40 + (32'd1 << 12), 32'hB0000000);

`ifdef DMEM_STATS_EN
    check("st_rd", stat_rd_OUT, 32'd2);
    check("st_wr", stat_wr_OUT, 32'd1);
    check("st_ab", stat_abort_OUT, 32'd1);
`endif

    // Reset in the middle of RD_WAIT.
    @(posedge CLK); #1;
    data_address_IN = 32'h120; dBlkRead_IN = 1'b1;
    tick; tick; tick;
    check("mr_busy_pre", busy_OUT, 1'b1);
    RESET = 1'b0;
    #1;
    check("mr_busy", busy_OUT, 1'b0);
    check("mr_rvld", block_read_valid_OUT, 1'b0);
    check("mr_rdata", block_read_OUT, '0);
    dBlkRead_IN = 1'b0;
    tick;
    @(negedge CLK) RESET = 1'b1;
    tick; tick;
    check("mr_idle", busy_OUT, 1'b0);
    check("mr_rvld2", block_read_valid_OUT, 1'b0);

    // Word write on the same edge as a block-write commit to the same word.
    for (int i = 0; i < 8; i++) blk[32*i +: 32] = 32'hC000_0000 + 32'(i);
    data_address_IN = 32'h60; block_write_IN = blk; dBlkWrite_IN = 1'b1;
    tick;
    tick; tick; tick;
    data_address_IN = 32'h67; data_write_IN = 32'h99; data_write_size_IN = 2'd1; MemWrite_IN = 1'b1;
    tick;
    MemWrite_IN = 1'b0; dBlkWrite_IN = 1'b0;
    check("col_wvld", block_write_valid_OUT, 1'b1);
    rd_word("col_w0", 32'h60, 32'hC0000000);
    rd_word("col_w1", 32'h64, 32'hC0000099);
    rd_word("col_w7", 32'h7C, 32'hC0000007);

`ifdef DMEM_STATS_EN
    check("st_rd_rst", stat_rd_OUT, 32'd0);
    check("st_wr_rst", stat_wr_OUT, 32'd1);
    check("st_ab_rst", stat_abort_OUT, 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, %0d/%0d checks passed so far", n_pass, n_chk);
    $fatal(1, "timeout");
  end
endmodule
